// File: rtl/mux_2to1_sel_counter.sv
// Registered copy of sel plus a saturating count of sel changes seen at clock edges.
// The counter sticks at all-ones so a long-running debug statistic never wraps back to a small value.
module mux_2to1_sel_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    output logic             sel_q,
    output logic [CNT_W-1:0] switch_cnt
);

    logic cnt_full;

    assign cnt_full = &switch_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q      <= 1'b0;
            switch_cnt <= '0;
        end else begin
            sel_q <= sel;
            // sel_q resets to 0, so a sel=1 on the first edge after reset counts as a switch
            if ((sel != sel_q) && !cnt_full) begin
                switch_cnt <= switch_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mux_2to1.sv
// 2-to-1 steering primitive: zero-latency combinational select, an enabled registered copy,
// and a select-switch statistic for debug.
module mux_2to1 #(
    parameter int               WIDTH   = 1,
    parameter int               CNT_W   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             out_q_valid,
    output logic             sel_q,
    output logic [CNT_W-1:0] switch_cnt
);

    // Independent of clk/rst/en so the path works even with the clock unconnected
    assign out = sel ? b : a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= RST_VAL;
            out_q_valid <= 1'b0;
        end else if (en) begin
            out_q       <= out;
            out_q_valid <= 1'b1;
        end
    end

    mux_2to1_sel_counter #(
        .CNT_W(CNT_W)
    ) u_sel_counter (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .sel_q     (sel_q),
        .switch_cnt(switch_cnt)
    );

endmodule

// File: tb/tb_mux_2to1.sv
// Scoreboard bench for mux_2to1: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_mux_2to1;

    localparam int K_OUT1  = 0;
    localparam int K_OUT8  = 1;
    localparam int K_OUTQ8 = 2;
    localparam int K_VAL8  = 3;
    localparam int K_SELQ8 = 4;
    localparam int K_CNT8  = 5;
    localparam int K_CNTC  = 6;

    typedef struct {
        int          kind;
        logic [15:0] exp;
        string       name;
    } sb_entry_t;

    sb_entry_t sb[$];
    event      ev_chk;
    int        tests = 0;
    int        fails = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=1 instance with clock and reset held idle
    logic       clk_idle, rst_idle;
    logic       a1, b1, sel1, en1;
    logic       out1, outq1, v1, selq1;
    logic [15:0] cnt1;

    // WIDTH=8 instance
    logic       rst8, sel8, en8;
    logic [7:0] a8, b8, out8, outq8;
    logic       v8, selq8;
    logic [15:0] cnt8;

    // CNT_W=2 instance for saturation
    logic       rstc, ac, bc, selc, enc;
    logic       outc, outqc, vc, selqc;
    logic [1:0] cntc;

    mux_2to1 #(.WIDTH(1)) u1 (
        .clk(clk_idle), .rst(rst_idle), .a(a1), .b(b1), .sel(sel1), .en(en1),
        .out(out1), .out_q(outq1), .out_q_valid(v1), .sel_q(selq1), .switch_cnt(cnt1)
    );

    mux_2to1 #(.WIDTH(8), .CNT_W(16)) u8 (
        .clk(clk), .rst(rst8), .a(a8), .b(b8), .sel(sel8), .en(en8),
        .out(out8), .out_q(outq8), .out_q_valid(v8), .sel_q(selq8), .switch_cnt(cnt8)
    );

    mux_2to1 #(.WIDTH(1), .CNT_W(2)) uc (
        .clk(clk), .rst(rstc), .a(ac), .b(bc), .sel(selc), .en(enc),
        .out(outc), .out_q(outqc), .out_q_valid(vc), .sel_q(selqc), .switch_cnt(cntc)
    );

    function automatic logic [15:0] actual(input int kind);
        case (kind)
            K_OUT1:  return {15'd0, out1};
            K_OUT8:  return {8'd0, out8};
            K_OUTQ8: return {8'd0, outq8};
            K_VAL8:  return {15'd0, v8};
            K_SELQ8: return {15'd0, selq8};
            K_CNT8:  return cnt8;
            K_CNTC:  return {14'd0, cntc};
            default: return 16'hxxxx;
        endcase
    endfunction

    // Monitor: drains the scoreboard each time stimulus says outputs have settled
    initial begin
        sb_entry_t e;
        logic [15:0] act;
        forever begin
            @(ev_chk);
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                act = actual(e.kind);
                tests++;
                if (act !== e.exp) begin
                    fails++;
                    $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic expect_val(input int kind, input logic [15:0] exp, input string name);
        sb.push_back('{kind, exp, name});
    endtask

    task automatic check_now();
        #1;
        -> ev_chk;
        #1;
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] truth;

    initial begin
        clk_idle = 1'b0; rst_idle = 1'b0;
        a1 = 0; b1 = 0; sel1 = 0; en1 = 0;
        rst8 = 1; a8 = 0; b8 = 0; sel8 = 0; en8 = 0;
        rstc = 1; ac = 0; bc = 0; selc = 0; enc = 0;

        // Directed combinational vectors, 10-unit steps
        a1 = 1; b1 = 0; sel1 = 0; expect_val(K_OUT1, 16'd1, "comb_a1_b0_s0"); check_now(); #8;
        a1 = 0; b1 = 1; sel1 = 0; expect_val(K_OUT1, 16'd0, "comb_a0_b1_s0"); check_now(); #8;
        a1 = 0; b1 = 1; sel1 = 1; expect_val(K_OUT1, 16'd1, "comb_a0_b1_s1"); check_now(); #8;
        a1 = 1; b1 = 0; sel1 = 1; expect_val(K_OUT1, 16'd0, "comb_a1_b0_s1"); check_now(); #8;

        // Exhaustive: index {sel,b,a} into hand-built truth table
        truth = 8'hCA;
        for (int i = 0; i < 8; i++) begin
            {sel1, b1, a1} = 3'(i);
            expect_val(K_OUT1, {15'd0, truth[i]}, $sformatf("comb_exh_%0d", i));
            check_now();
            #8;
        end

        // Reset state while rst held
        expect_val(K_OUTQ8, 16'h0000, "rst_out_q");
        expect_val(K_VAL8,  16'd0,    "rst_valid");
        expect_val(K_SELQ8, 16'd0,    "rst_sel_q");
        expect_val(K_CNT8,  16'd0,    "rst_cnt");
        expect_val(K_CNTC,  16'd0,    "rst_cntc");
        check_now();

        @(negedge clk);
        rst8 = 0; rstc = 0;
        a8 = 8'hA5; b8 = 8'h3C; sel8 = 0; en8 = 1; selc = 0;

        step(); // E1
        expect_val(K_OUTQ8, 16'h00A5, "e1_out_q_a");
        expect_val(K_VAL8,  16'd1,    "e1_valid");
        expect_val(K_CNT8,  16'd0,    "e1_cnt");
        expect_val(K_CNTC,  16'd0,    "e1_cntc");
        check_now();

        step(); // E2, sel held
        expect_val(K_CNT8, 16'd0, "e2_cnt_hold_sel");
        expect_val(K_CNTC, 16'd0, "e2_cntc_hold_sel");
        check_now();

        sel8 = 1; selc = 1;
        step(); // E3
        expect_val(K_OUTQ8, 16'h003C, "e3_out_q_b");
        expect_val(K_SELQ8, 16'd1,    "e3_sel_q");
        expect_val(K_CNT8,  16'd1,    "e3_cnt");
        expect_val(K_CNTC,  16'd1,    "e3_cntc");
        check_now();

        en8 = 0; a8 = 8'h11; b8 = 8'h22; sel8 = 0; selc = 0;
        expect_val(K_OUT8, 16'h0011, "en0_out_tracks_a");
        check_now();
        step(); // E4
        expect_val(K_OUTQ8, 16'h003C, "e4_out_q_hold");
        expect_val(K_VAL8,  16'd1,    "e4_valid_hold");
        expect_val(K_CNT8,  16'd2,    "e4_cnt");
        expect_val(K_CNTC,  16'd2,    "e4_cntc");
        check_now();

        sel8 = 1; selc = 1;
        expect_val(K_OUT8, 16'h0022, "en0_out_tracks_b");
        check_now();
        step(); // E5
        expect_val(K_CNT8, 16'd3, "e5_cnt");
        expect_val(K_CNTC, 16'd3, "e5_cntc");
        check_now();

        sel8 = 0; selc = 0;
        step(); // E6
        expect_val(K_CNT8, 16'd4, "e6_cnt");
        expect_val(K_CNTC, 16'd3, "e6_cntc_sat");
        check_now();

        sel8 = 1; selc = 1;
        step(); // E7
        expect_val(K_CNT8,  16'd5,    "e7_cnt");
        expect_val(K_OUTQ8, 16'h003C, "e7_out_q_hold");
        expect_val(K_CNTC,  16'd3,    "e7_cntc_sat");
        check_now();

        selc = 0;
        step(); // E8
        expect_val(K_CNTC, 16'd3, "e8_cntc_sat");
        check_now();

        step(); // E9, sel held
        expect_val(K_CNTC, 16'd3, "e9_cntc_hold");
        check_now();

        // Async reset between edges
        #1;
        rst8 = 1;
        expect_val(K_OUTQ8, 16'h0000, "arst_out_q");
        expect_val(K_VAL8,  16'd0,    "arst_valid");
        expect_val(K_SELQ8, 16'd0,    "arst_sel_q");
        expect_val(K_CNT8,  16'd0,    "arst_cnt");
        expect_val(K_OUT8,  16'h0022, "arst_out_unchanged");
        check_now();

        @(negedge clk);
        rst8 = 0; a8 = 8'hA5; b8 = 8'h3C; sel8 = 1; en8 = 1;
        step();
        expect_val(K_CNT8,  16'd1,    "post_rst_first_edge_cnt");
        expect_val(K_OUTQ8, 16'h003C, "post_rst_out_q");
        expect_val(K_VAL8,  16'd1,    "post_rst_valid");
        check_now();

        #5;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
